// File: rtl/multicore_run_controller_if.sv
//------------------------------------------------------------------------------
// multicore_run_controller_if : host/DRAM/core bundle for the run controller
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface multicore_run_controller_if #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int CYC_W     = 32
);
   logic                 start;
   logic [NUM_CORES-1:0] core_mask;
   logic                 load_valid;
   logic [DATA_W-1:0]    load_data;
   logic                 load_last;
   logic                 load_ready;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic                 mem_we;
   logic [DATA_W-1:0]    mem_rdata;
   logic [NUM_CORES-1:0] core_en;
   logic [NUM_CORES-1:0] core_end;
   logic                 rd_valid;
   logic [DATA_W-1:0]    rd_data;
   logic                 rd_ready;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic [CYC_W-1:0]     cycle_count;

   // System side: host stream, DRAM read data and core status.
   modport master (
      output start, core_mask, load_valid, load_data, load_last,
             mem_rdata, core_end, rd_ready,
      input  load_ready, mem_addr, mem_wdata, mem_we, core_en,
             rd_valid, rd_data, busy, done, err, cycle_count
   );

   modport slave (
      input  start, core_mask, load_valid, load_data, load_last,
             mem_rdata, core_end, rd_ready,
      output load_ready, mem_addr, mem_wdata, mem_we, core_en,
             rd_valid, rd_data, busy, done, err, cycle_count
   );
endinterface

`default_nettype wire

// File: rtl/multicore_run_controller.sv
//------------------------------------------------------------------------------
// multicore_run_controller : load image, run masked cores, stream results back
// Revision 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multicore_run_controller #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int OUT_BASE  = 'h020,
   parameter int OUT_LEN   = 16,
   parameter int CYC_W     = 32
) (
   input wire logic                   clk,
   input wire logic                   rst,
   multicore_run_controller_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_RUN     = 3'd2,
      S_ISSUE   = 3'd3,
      S_CAPTURE = 3'd4,
      S_HOLD    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam logic [ADDR_W-1:0] c_addr_max = '1;
   localparam logic [ADDR_W-1:0] c_out_base = ADDR_W'(OUT_BASE);
   localparam logic [ADDR_W-1:0] c_last_rd  = ADDR_W'(OUT_LEN - 1);
   localparam logic [CYC_W-1:0]  c_cyc_max  = '1;

   state_t               r_state;
   logic [NUM_CORES-1:0] r_mask;
   logic [ADDR_W-1:0]    r_wr_ptr;
   logic [ADDR_W-1:0]    r_rd_ptr;
   logic [CYC_W-1:0]     r_cycle;
   logic [NUM_CORES-1:0] r_core_en;
   logic                 r_load_ready;
   logic                 r_rd_valid;
   logic [DATA_W-1:0]    r_rd_data;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;

   logic [ADDR_W-1:0]    w_mem_addr;
   logic [DATA_W-1:0]    w_mem_wdata;
   logic                 w_mem_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_mask       <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_cycle      <= '0;
         r_core_en    <= '0;
         r_load_ready <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_data    <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (|bus.core_mask) begin
                     r_mask       <= bus.core_mask;
                     r_wr_ptr     <= '0;
                     r_cycle      <= '0;
                     r_load_ready <= 1'b1;
                     r_busy       <= 1'b1;
                     r_state      <= S_LOAD;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (bus.load_valid) begin
                  // Pointer parks at the top address rather than wrapping.
                  if (r_wr_ptr != c_addr_max) begin
                     r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                  end
                  if (bus.load_last || (r_wr_ptr == c_addr_max)) begin
                     r_err        <= ~bus.load_last;
                     r_load_ready <= 1'b0;
                     r_core_en    <= r_mask;
                     r_state      <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if ((bus.core_end & r_mask) == r_mask) begin
                  r_core_en <= '0;
                  r_rd_ptr  <= '0;
                  r_state   <= S_ISSUE;
               end else if (r_cycle != c_cyc_max) begin
                  r_cycle <= r_cycle + CYC_W'(1);
               end
            end
            S_ISSUE: begin
               r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_rd_data  <= bus.mem_rdata;
               r_rd_valid <= 1'b1;
               r_state    <= S_HOLD;
            end
            S_HOLD: begin
               if (bus.rd_ready) begin
                  r_rd_valid <= 1'b0;
                  r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
                  if (r_rd_ptr == c_last_rd) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Load writes pass straight through so every accepted beat lands in the same cycle.
   always_comb begin
      w_mem_addr  = '0;
      w_mem_wdata = '0;
      w_mem_we    = 1'b0;
      case (r_state)
         S_LOAD: begin
            w_mem_addr  = r_wr_ptr;
            w_mem_wdata = bus.load_data;
            w_mem_we    = bus.load_valid;
         end
         S_ISSUE, S_CAPTURE, S_HOLD: begin
            w_mem_addr = c_out_base + r_rd_ptr;
         end
         default: begin
            w_mem_addr = '0;
         end
      endcase
   end

   assign bus.load_ready  = r_load_ready;
   assign bus.mem_addr    = w_mem_addr;
   assign bus.mem_wdata   = w_mem_wdata;
   assign bus.mem_we      = w_mem_we;
   assign bus.core_en     = r_core_en;
   assign bus.rd_valid    = r_rd_valid;
   assign bus.rd_data     = r_rd_data;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.err         = r_err;
   assign bus.cycle_count = r_cycle;

endmodule

`default_nettype wire
